// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: forward selects, ALU source
// selects and the stall FSM state type.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MW   = 2'b01;
  localparam logic [1:0] FWD_EM   = 2'b10;

  localparam logic [1:0] ALU1_SRC_PC = 2'b01;
  localparam logic [1:0] ALU_SRC_REG = 2'b00;

  typedef enum logic [1:0] {
    Idle,
    LuWait,
    CtrlWait
  } haz_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side signal bundle of the hazard controller. The pipeline owns the master
// modport, the controller the slave modport.
interface hazard_ctrl_unit_if #(
  parameter int unsigned REG_AW = 3
);

  logic              id_valid;
  logic [REG_AW-1:0] id_r1_num;
  logic [REG_AW-1:0] id_r2_num;
  logic              id_r1_used;
  logic              id_r2_used;
  logic              id_is_ctrl;
  logic [REG_AW-1:0] ex_r1_num;
  logic [REG_AW-1:0] ex_r2_num;
  logic [1:0]        ex_alu1_sel;
  logic [1:0]        ex_alu2_sel;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_wr_num;
  logic              ex_wr_en;
  logic [REG_AW-1:0] em_wr_num;
  logic [REG_AW-1:0] mw_wr_num;
  logic              em_wr_en;
  logic              mw_wr_en;

  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic              stall_pc;
  logic              stall_ifid;
  logic              ifid_nop;
  logic              bubble_idex;
  logic              busy;

  modport master (
    output id_valid, id_r1_num, id_r2_num, id_r1_used, id_r2_used, id_is_ctrl,
    output ex_r1_num, ex_r2_num, ex_alu1_sel, ex_alu2_sel, ex_mem_read, ex_wr_num, ex_wr_en,
    output em_wr_num, mw_wr_num, em_wr_en, mw_wr_en,
    input  forward_a, forward_b, stall_pc, stall_ifid, ifid_nop, bubble_idex, busy
  );

  modport slave (
    input  id_valid, id_r1_num, id_r2_num, id_r1_used, id_r2_used, id_is_ctrl,
    input  ex_r1_num, ex_r2_num, ex_alu1_sel, ex_alu2_sel, ex_mem_read, ex_wr_num, ex_wr_en,
    input  em_wr_num, mw_wr_num, em_wr_en, mw_wr_en,
    output forward_a, forward_b, stall_pc, stall_ifid, ifid_nop, bubble_idex, busy
  );

endinterface

// File: rtl/fwd_select.sv
// Priority forward-select for one EX operand: EX/MEM beats MEM/WB; en_i gates the
// whole chain off when the ALU operand does not come from the register file.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 3
) (
  input  logic [REG_AW-1:0] src_num_i,
  input  logic              en_i,
  input  logic [REG_AW-1:0] em_wr_num_i,
  input  logic              em_wr_en_i,
  input  logic [REG_AW-1:0] mw_wr_num_i,
  input  logic              mw_wr_en_i,
  output logic [1:0]        fwd_o
);

  always_comb begin
    fwd_o = FWD_NONE;
    if (en_i) begin
      if (em_wr_en_i && (src_num_i == em_wr_num_i)) begin
        fwd_o = FWD_EM;
      end else if (mw_wr_en_i && (src_num_i == mw_wr_num_i)) begin
        fwd_o = FWD_MW;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller: combinational EX operand forwarding plus a stall FSM for
// multi-cycle load-use interlock and counted control-flow freeze. Optional stall perf
// counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned LU_LAT   = 1,
  parameter int unsigned CTRL_LAT = 3
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int unsigned PERF_W   = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hazard_ctrl_unit_if.slave      hz_bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]      lu_stall_cnt,
  output logic [PERF_W-1:0]      ctrl_stall_cnt
`endif
);

  localparam int unsigned MaxLat = (LU_LAT > CTRL_LAT) ? LU_LAT : CTRL_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  logic [1:0] fwd_a_raw, fwd_b_raw;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src_num_i   (hz_bus.ex_r1_num),
    .en_i        (hz_bus.ex_alu1_sel != ALU1_SRC_PC),
    .em_wr_num_i (hz_bus.em_wr_num),
    .em_wr_en_i  (hz_bus.em_wr_en),
    .mw_wr_num_i (hz_bus.mw_wr_num),
    .mw_wr_en_i  (hz_bus.mw_wr_en),
    .fwd_o       (fwd_a_raw)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src_num_i   (hz_bus.ex_r2_num),
    .en_i        (hz_bus.ex_alu2_sel == ALU_SRC_REG),
    .em_wr_num_i (hz_bus.em_wr_num),
    .em_wr_en_i  (hz_bus.em_wr_en),
    .mw_wr_num_i (hz_bus.mw_wr_num),
    .mw_wr_en_i  (hz_bus.mw_wr_en),
    .fwd_o       (fwd_b_raw)
  );

  logic lu_hit;
  assign lu_hit = hz_bus.id_valid && hz_bus.ex_mem_read && hz_bus.ex_wr_en &&
                  ((hz_bus.id_r1_used && (hz_bus.id_r1_num == hz_bus.ex_wr_num)) ||
                   (hz_bus.id_r2_used && (hz_bus.id_r2_num == hz_bus.ex_wr_num)));

  haz_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             lu_stall, ctrl_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= Idle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lu_stall   = 1'b0;
    ctrl_stall = 1'b0;
    case (state_q)
      Idle: begin
        // Load-use wins; a held ctrl instruction is re-detected once released.
        if (lu_hit) begin
          lu_stall = 1'b1;
          if (LU_LAT > 1) begin
            state_d = LuWait;
            cnt_d   = CntW'(LU_LAT - 2);
          end
        end else if (hz_bus.id_valid && hz_bus.id_is_ctrl) begin
          ctrl_stall = 1'b1;
          state_d    = CtrlWait;
          cnt_d      = CntW'(CTRL_LAT - 1);
        end
      end
      LuWait: begin
        lu_stall = 1'b1;
        if (cnt_q == '0) state_d = Idle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      CtrlWait: begin
        ctrl_stall = 1'b1;
        if (cnt_q == '0) state_d = Idle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = Idle;
        cnt_d   = '0;
      end
    endcase
  end

  // Every output is forced quiet while reset is held, forwarding included.
  assign hz_bus.forward_a   = rst_n ? fwd_a_raw : FWD_NONE;
  assign hz_bus.forward_b   = rst_n ? fwd_b_raw : FWD_NONE;
  assign hz_bus.stall_pc    = rst_n && (lu_stall || ctrl_stall);
  assign hz_bus.stall_ifid  = rst_n && lu_stall;
  assign hz_bus.bubble_idex = rst_n && lu_stall;
  assign hz_bus.ifid_nop    = rst_n && ctrl_stall;
  assign hz_bus.busy        = rst_n && (state_q != Idle);

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] lu_cnt_q, lu_cnt_d, ctrl_cnt_q, ctrl_cnt_d;

  always_comb begin
    lu_cnt_d   = lu_cnt_q;
    ctrl_cnt_d = ctrl_cnt_q;
    if (lu_stall && (lu_cnt_q != '1))     lu_cnt_d   = lu_cnt_q + 1'b1;
    if (ctrl_stall && (ctrl_cnt_q != '1)) ctrl_cnt_d = ctrl_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lu_cnt_q   <= '0;
      ctrl_cnt_q <= '0;
    end else begin
      lu_cnt_q   <= lu_cnt_d;
      ctrl_cnt_q <= ctrl_cnt_d;
    end
  end

  assign lu_stall_cnt   = lu_cnt_q;
  assign ctrl_stall_cnt = ctrl_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: one DUT with default latencies, one with LU_LAT=3,
// both fed the same pipeline inputs.
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_AW(3)) bus0 ();
  hazard_ctrl_unit_if #(.REG_AW(3)) bus1 ();

  assign bus1.id_valid    = bus0.id_valid;
  assign bus1.id_r1_num   = bus0.id_r1_num;
  assign bus1.id_r2_num   = bus0.id_r2_num;
  assign bus1.id_r1_used  = bus0.id_r1_used;
  assign bus1.id_r2_used  = bus0.id_r2_used;
  assign bus1.id_is_ctrl  = bus0.id_is_ctrl;
  assign bus1.ex_r1_num   = bus0.ex_r1_num;
  assign bus1.ex_r2_num   = bus0.ex_r2_num;
  assign bus1.ex_alu1_sel = bus0.ex_alu1_sel;
  assign bus1.ex_alu2_sel = bus0.ex_alu2_sel;
  assign bus1.ex_mem_read = bus0.ex_mem_read;
  assign bus1.ex_wr_num   = bus0.ex_wr_num;
  assign bus1.ex_wr_en    = bus0.ex_wr_en;
  assign bus1.em_wr_num   = bus0.em_wr_num;
  assign bus1.mw_wr_num   = bus0.mw_wr_num;
  assign bus1.em_wr_en    = bus0.em_wr_en;
  assign bus1.mw_wr_en    = bus0.mw_wr_en;

`ifdef HAZ_PERF_CNT_EN
  logic [1:0] lu_cnt0, ctrl_cnt0, lu_cnt1, ctrl_cnt1;

  hazard_ctrl_unit #(.REG_AW(3), .LU_LAT(1), .CTRL_LAT(3), .PERF_W(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hz_bus         (bus0),
    .lu_stall_cnt   (lu_cnt0),
    .ctrl_stall_cnt (ctrl_cnt0)
  );

  hazard_ctrl_unit #(.REG_AW(3), .LU_LAT(3), .CTRL_LAT(3), .PERF_W(2)) dut_lu3 (
    .clk            (clk),
    .rst_n          (rst_n),
    .hz_bus         (bus1),
    .lu_stall_cnt   (lu_cnt1),
    .ctrl_stall_cnt (ctrl_cnt1)
  );
`else
  hazard_ctrl_unit #(.REG_AW(3), .LU_LAT(1), .CTRL_LAT(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .hz_bus (bus0)
  );

  hazard_ctrl_unit #(.REG_AW(3), .LU_LAT(3), .CTRL_LAT(3)) dut_lu3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .hz_bus (bus1)
  );
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {stall_pc, stall_ifid, ifid_nop, bubble_idex, busy}
  function automatic logic [4:0] ctl0();
    return {bus0.stall_pc, bus0.stall_ifid, bus0.ifid_nop, bus0.bubble_idex, bus0.busy};
  endfunction

  function automatic logic [4:0] ctl1();
    return {bus1.stall_pc, bus1.stall_ifid, bus1.ifid_nop, bus1.bubble_idex, bus1.busy};
  endfunction

  task automatic idle_inputs();
    bus0.id_valid    = 1'b0;
    bus0.id_r1_num   = '0;
    bus0.id_r2_num   = '0;
    bus0.id_r1_used  = 1'b0;
    bus0.id_r2_used  = 1'b0;
    bus0.id_is_ctrl  = 1'b0;
    bus0.ex_r1_num   = 3'd7;
    bus0.ex_r2_num   = 3'd7;
    bus0.ex_alu1_sel = 2'b00;
    bus0.ex_alu2_sel = 2'b00;
    bus0.ex_mem_read = 1'b0;
    bus0.ex_wr_num   = '0;
    bus0.ex_wr_en    = 1'b0;
    bus0.em_wr_num   = '0;
    bus0.mw_wr_num   = '0;
    bus0.em_wr_en    = 1'b0;
    bus0.mw_wr_en    = 1'b0;
  endtask

  // Drive a load at EX writing r5 and an ID instruction reading r5 through rs2.
  task automatic load_use_inputs(input logic ctrl);
    idle_inputs();
    bus0.id_valid    = 1'b1;
    bus0.id_r2_num   = 3'd5;
    bus0.id_r2_used  = 1'b1;
    bus0.id_is_ctrl  = ctrl;
    bus0.ex_mem_read = 1'b1;
    bus0.ex_wr_num   = 3'd5;
    bus0.ex_wr_en    = 1'b1;
  endtask

  task automatic branch_inputs();
    idle_inputs();
    bus0.id_valid   = 1'b1;
    bus0.id_is_ctrl = 1'b1;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Reset: forwarding match and a branch present, everything must stay quiet.
    cyc();
    bus0.ex_r1_num = 3'd3; bus0.em_wr_num = 3'd3; bus0.em_wr_en = 1'b1;
    bus0.ex_r2_num = 3'd3; bus0.id_valid = 1'b1; bus0.id_is_ctrl = 1'b1;
    #1;
    check_eq("rst_fwd_a", 32'(bus0.forward_a), 32'd0);
    check_eq("rst_fwd_b", 32'(bus0.forward_b), 32'd0);
    check_eq("rst_ctl0", 32'(ctl0()), 32'd0);
    check_eq("rst_ctl1", 32'(ctl1()), 32'd0);
    cyc();
    idle_inputs();
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_ctl", 32'(ctl0()), 32'd0);

    // Forwarding chain on operand A.
    cyc();
    bus0.ex_r1_num = 3'd3;
    bus0.em_wr_num = 3'd3; bus0.em_wr_en = 1'b1;
    bus0.mw_wr_num = 3'd3; bus0.mw_wr_en = 1'b1;
    #1; check_eq("fwd_a_both", 32'(bus0.forward_a), 32'h2);
    bus0.em_wr_en = 1'b0;
    #1; check_eq("fwd_a_mw", 32'(bus0.forward_a), 32'h1);
    bus0.ex_alu1_sel = 2'b01;
    #1; check_eq("fwd_a_pc_gate", 32'(bus0.forward_a), 32'h0);
    bus0.ex_alu1_sel = 2'b10; bus0.em_wr_en = 1'b1;
    #1; check_eq("fwd_a_sel10", 32'(bus0.forward_a), 32'h2);
    bus0.ex_r1_num = 3'd4;
    #1; check_eq("fwd_a_nomatch", 32'(bus0.forward_a), 32'h0);
    bus0.ex_r1_num = 3'd0; bus0.em_wr_num = 3'd0;
    #1; check_eq("fwd_a_r0", 32'(bus0.forward_a), 32'h2);

    // Operand B chain and its select gate.
    idle_inputs();
    bus0.ex_r2_num = 3'd6; bus0.em_wr_num = 3'd6; bus0.em_wr_en = 1'b1;
    bus0.ex_alu2_sel = 2'b10;
    #1; check_eq("fwd_b_gate", 32'(bus0.forward_b), 32'h0);
    bus0.ex_alu2_sel = 2'b00;
    #1; check_eq("fwd_b_em", 32'(bus0.forward_b), 32'h2);
    bus0.em_wr_en = 1'b0; bus0.mw_wr_num = 3'd6; bus0.mw_wr_en = 1'b1;
    #1; check_eq("fwd_b_mw", 32'(bus0.forward_b), 32'h1);

    // Load-use: unused source does not stall; then 1 vs 3 cycle interlock.
    cyc(); load_use_inputs(1'b0); bus0.id_r2_used = 1'b0;
    #1; check_eq("lu_unused", 32'(ctl0()), 32'd0);
    cyc(); load_use_inputs(1'b0);
    #1;
    check_eq("lu_c1_dut", 32'(ctl0()), 32'b11010);
    check_eq("lu_c1_lu3", 32'(ctl1()), 32'b11010);
    for (int i = 2; i <= 3; i++) begin
      cyc(); idle_inputs();
      #1;
      check_eq($sformatf("lu_c%0d_dut", i), 32'(ctl0()), 32'd0);
      check_eq($sformatf("lu_c%0d_lu3", i), 32'(ctl1()), 32'b11011);
    end
    cyc();
    #1;
    check_eq("lu_c4_lu3", 32'(ctl1()), 32'd0);

    // Branch freeze: 4 cycles, id_is_ctrl kept pulsing during the wait is ignored.
    cyc(); branch_inputs();
    #1;
    check_eq("br_c1", 32'(ctl0()), 32'b10100);
    check_eq("br_c1_lu3", 32'(ctl1()), 32'b10100);
    for (int i = 2; i <= 4; i++) begin
      cyc();
      bus0.id_is_ctrl = (i != 3);
      #1;
      check_eq($sformatf("br_c%0d", i), 32'(ctl0()), 32'b10101);
    end
    cyc(); idle_inputs();
    #1;
    check_eq("br_c5", 32'(ctl0()), 32'd0);
    check_eq("br_c5_lu3", 32'(ctl1()), 32'd0);

    // Load-use and ctrl together: one interlock cycle, then the 4-cycle freeze.
    cyc(); load_use_inputs(1'b1);
    #1; check_eq("mix_c1", 32'(ctl0()), 32'b11010);
    cyc(); branch_inputs();
    #1; check_eq("mix_c2", 32'(ctl0()), 32'b10100);
    for (int i = 3; i <= 5; i++) begin
      cyc();
      #1; check_eq($sformatf("mix_c%0d", i), 32'(ctl0()), 32'b10101);
    end
    cyc(); idle_inputs();
    #1; check_eq("mix_c6", 32'(ctl0()), 32'd0);
    repeat (4) cyc();

    // Reset on the second CTRL_WAIT cycle aborts the freeze.
    cyc(); branch_inputs();
    #1; check_eq("rw_c1", 32'(ctl0()), 32'b10100);
    cyc();
    #1; check_eq("rw_c2", 32'(ctl0()), 32'b10101);
    cyc();
    rst_n = 1'b0;
    bus0.ex_r1_num = 3'd2; bus0.em_wr_num = 3'd2; bus0.em_wr_en = 1'b1;
    #1;
    check_eq("rw_rst_ctl", 32'(ctl0()), 32'd0);
    check_eq("rw_rst_fwd", 32'(bus0.forward_a), 32'd0);
    cyc(); idle_inputs(); rst_n = 1'b1;
    #1;
    check_eq("rw_after_ctl", 32'(ctl0()), 32'd0);
    check_eq("rw_after_lu3", 32'(ctl1()), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    check_eq("perf_clr_lu", 32'(lu_cnt0), 32'd0);
    check_eq("perf_clr_ctrl", 32'(ctrl_cnt0), 32'd0);
`endif

    // Fresh branch after reset: full 4-cycle freeze, counter climbs and saturates.
    cyc(); branch_inputs();
    #1; check_eq("rb_c1", 32'(ctl0()), 32'b10100);
    cyc(); idle_inputs();
    for (int i = 2; i <= 4; i++) begin
      #1; check_eq($sformatf("rb_c%0d", i), 32'(ctl0()), 32'b10101);
`ifdef HAZ_PERF_CNT_EN
      check_eq($sformatf("perf_ctrl_c%0d", i), 32'(ctrl_cnt0), 32'(i - 1));
`endif
      cyc();
    end
    #1;
    check_eq("rb_c5", 32'(ctl0()), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    check_eq("perf_ctrl_sat", 32'(ctrl_cnt0), 32'd3);
    check_eq("perf_lu_idle", 32'(lu_cnt0), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
